// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports, one synchronous write port,
// optional write-to-read bypass and zero register, plus a one-entry-per-cycle clear engine.
module reg_file_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    input  logic              CLEAR_REQ,
    output logic              BUSY,
    output logic              WR_DROP
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cidx, cidx_nxt;
    logic [DATA_W-1:0] regs [DEPTH];
    logic              clr_en;
    logic              zero_wr;
    logic              wr_acc;
    logic              drop_nxt;

    assign zero_wr  = (ZERO_REG != 0) && (INADDRESS == '0);
    // A clear request in IDLE wins over a coincident write.
    assign wr_acc   = WRITE && !RESET && (state == IDLE) && !CLEAR_REQ && !zero_wr;
    assign drop_nxt = WRITE && ((state == CLEAR) || CLEAR_REQ || zero_wr);

    always_comb begin
        state_nxt = state;
        cidx_nxt  = cidx;
        clr_en    = 1'b0;
        case (state)
            IDLE: begin
                if (CLEAR_REQ) begin
                    state_nxt = CLEAR;
                    cidx_nxt  = '0;
                end
            end
            CLEAR: begin
                clr_en   = 1'b1;
                cidx_nxt = cidx + 1'b1;
                if (&cidx) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            cidx    <= '0;
            BUSY    <= 1'b0;
            WR_DROP <= 1'b0;
        end else begin
            state   <= state_nxt;
            cidx    <= cidx_nxt;
            BUSY    <= (state_nxt == CLEAR);
            WR_DROP <= drop_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (clr_en) begin
            regs[cidx] <= '0;
        end else if (wr_acc) begin
            regs[INADDRESS] <= IN;
        end
    end

    // Zero register overrides bypass, so it is applied last.
    always_comb begin
        OUT1 = regs[OUT1ADDRESS];
        if ((BYPASS != 0) && wr_acc && (OUT1ADDRESS == INADDRESS)) OUT1 = IN;
        if ((ZERO_REG != 0) && (OUT1ADDRESS == '0)) OUT1 = '0;
    end

    always_comb begin
        OUT2 = regs[OUT2ADDRESS];
        if ((BYPASS != 0) && wr_acc && (OUT2ADDRESS == INADDRESS)) OUT2 = IN;
        if ((ZERO_REG != 0) && (OUT2ADDRESS == '0)) OUT2 = '0;
    end
endmodule
